// File: rtl/riscv_pkg.sv
// Shared types and constants for the data-memory arbiter and its monitor scanner.
package riscv_pkg;

    // Scanner phases: waiting for refresh, issuing window reads, refresh gap.
    typedef enum logic [1:0] {
        SCAN_IDLE  = 2'd0,
        SCAN_ISSUE = 2'd1,
        SCAN_GAP   = 2'd2
    } scan_state_e;

    // First byte address of the monitored RAM window.
    localparam logic [31:0] DEF_MON_BASE = 32'h0000_0200;

    // RAM read data appears this many cycles after the read enable.
    // The single pend stage in the arbiter is built around a value of 1.
    localparam int unsigned RAM_RD_LATENCY = 32'd1;

    // Byte address of monitored word idx.
    function automatic logic [31:0] mon_word_addr(input logic [31:0] base,
                                                  input logic [2:0]  idx);
        return base + {27'd0, idx, 2'b00};
    endfunction

endpackage

// File: rtl/refresh_timer.sv
// Loadable down-counter pacing the monitor scans; reports when it has run out.
module refresh_timer #(
    parameter int unsigned REFRESH = 32'd50000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic load_i,
    output logic expired_o,
    output logic last_o
);

    localparam int unsigned W = $clog2(REFRESH + 32'd1);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Reload on request, otherwise count down and stop at zero.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = W'(REFRESH);
        end else if (count_q != {W{1'b0}}) begin
            count_d = count_q - W'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Counter register; starts expired so the first scan begins at once.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= {W{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = (count_q == {W{1'b0}});
    assign last_o    = (count_q == W'(1));

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the data RAM between the core (always first, never stalled) and a
// background scanner that mirrors a small RAM window into display shadows.
module dmem_arbiter
    import riscv_pkg::*;
#(
    parameter logic [31:0] MON_BASE  = DEF_MON_BASE,
    parameter int unsigned MON_WORDS = 32'd4,
    parameter int unsigned REFRESH   = 32'd50000
) (
    input  logic        m_clock,
    input  logic        p_reset,
    input  logic        core_read,
    input  logic        core_write,
    input  logic [31:0] core_addr,
    input  logic [31:0] core_wdata,
    output logic [31:0] core_rdata,
    input  logic        mon_en,
    input  logic [2:0]  mon_sel,
    output logic [31:0] mon_data,
    output logic        mon_valid,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    output logic        ram_rden,
    output logic        ram_wren,
    input  logic [31:0] ram_rdata
);

    localparam logic [2:0]  LAST_IDX  = 3'(MON_WORDS - 32'd1);
    localparam logic [31:0] WIN_BYTES = 32'(MON_WORDS * 32'd4);

    scan_state_e state_q;
    logic [2:0]  idx_q;
    logic        pend_q;
    logic [2:0]  pend_idx_q;
    logic [31:0] shadow_q [8];
    logic        mon_valid_q;

    logic        core_req_s;
    logic        active_s;
    logic        issue_s;
    logic        last_issue_s;
    logic        timer_expired_s;
    logic        timer_last_s;
    logic [31:0] snoop_off_s;
    logic        snoop_s;
    logic [2:0]  snoop_idx_s;

    // The scanner wants the RAM while issuing, or from idle once refresh ran
    // out; it only gets it in cycles the core leaves free. Reset silences it.
    assign core_req_s   = core_read | core_write;
    assign active_s     = p_reset & mon_en &
                          ((state_q == SCAN_ISSUE) | ((state_q == SCAN_IDLE) & timer_expired_s));
    assign issue_s      = active_s & ~core_req_s;
    assign last_issue_s = issue_s & (idx_q == LAST_IDX);

    // Window hit test on the offset so a single unsigned compare covers both bounds.
    assign snoop_off_s = core_addr - MON_BASE;
    assign snoop_s     = core_write & (snoop_off_s < WIN_BYTES) & (core_addr[1:0] == 2'b00);
    assign snoop_idx_s = snoop_off_s[4:2];

    refresh_timer #(
        .REFRESH (REFRESH)
    ) u_refresh_timer (
        .clk_i     (m_clock),
        .rst_ni    (p_reset),
        .load_i    (last_issue_s),
        .expired_o (timer_expired_s),
        .last_o    (timer_last_s)
    );

    // Scanner FSM and word index; leaves the gap one cycle before the timer
    // reaches zero so the next scan starts as soon as it is expired.
    always_ff @(posedge m_clock or negedge p_reset) begin
        if (!p_reset) begin
            state_q <= SCAN_IDLE;
            idx_q   <= 3'd0;
        end else if (!mon_en) begin
            state_q <= SCAN_IDLE;
            idx_q   <= 3'd0;
        end else if (last_issue_s) begin
            state_q <= SCAN_GAP;
            idx_q   <= 3'd0;
        end else if (issue_s) begin
            state_q <= SCAN_ISSUE;
            idx_q   <= idx_q + 3'd1;
        end else if (active_s) begin
            state_q <= SCAN_ISSUE;
        end else begin
            case (state_q)
                SCAN_GAP: begin
                    if (timer_last_s || timer_expired_s) begin
                        state_q <= SCAN_IDLE;
                    end
                end
                SCAN_IDLE, SCAN_ISSUE: begin
                    state_q <= state_q;
                end
                default: begin
                    state_q <= SCAN_IDLE;
                    idx_q   <= 3'd0;
                end
            endcase
        end
    end

    // Pending read tracking, shadow capture and write snoop; the snoop is
    // written last so it overrides a capture of the same word.
    always_ff @(posedge m_clock or negedge p_reset) begin
        if (!p_reset) begin
            pend_q      <= 1'b0;
            pend_idx_q  <= 3'd0;
            mon_valid_q <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                shadow_q[i] <= 32'd0;
            end
        end else begin
            pend_q     <= issue_s;
            pend_idx_q <= idx_q;
            if (pend_q) begin
                shadow_q[pend_idx_q] <= ram_rdata;
                if (pend_idx_q == LAST_IDX) begin
                    mon_valid_q <= 1'b1;
                end
            end
            if (snoop_s) begin
                shadow_q[snoop_idx_s] <= core_wdata;
            end
        end
    end

    // RAM port mux: core pass-through, else scanner read, else quiet.
    always_comb begin
        ram_addr  = 32'd0;
        ram_wdata = 32'd0;
        ram_rden  = 1'b0;
        ram_wren  = 1'b0;
        if (core_req_s) begin
            ram_addr  = core_addr;
            ram_wdata = core_wdata;
            ram_rden  = core_read;
            ram_wren  = core_write;
        end else if (issue_s) begin
            ram_addr  = mon_word_addr(MON_BASE, idx_q);
            ram_rden  = 1'b1;
        end else begin
            ram_addr  = 32'd0;
            ram_wdata = 32'd0;
        end
    end

    // Display read-out; selections beyond the window read as zero.
    always_comb begin
        mon_data = 32'd0;
        if ({29'd0, mon_sel} < MON_WORDS) begin
            mon_data = shadow_q[mon_sel];
        end else begin
            mon_data = 32'd0;
        end
    end

    assign core_rdata = ram_rdata;
    assign mon_valid  = mon_valid_q;

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the single-port data RAM between the rv32i core's data port and a background monitor scanner. Sits between `rv32i_core`, `ram_wrap` and `seg7_ctrl` in the top level. The core always has priority and is never stalled. The scanner uses idle RAM cycles to copy a small window of RAM into shadow registers that drive the 7-segment display. The block replaces the static MODE multiplexer, so the display can show live RAM contents while the program runs.

## Interface
Parameters:
- MON_BASE, 32'h0000_0200, byte address of the first monitored word
- MON_WORDS, 4, number of consecutive 32-bit words monitored (1..8)
- REFRESH, 50000, idle cycles between the end of one scan and the start of the next (≥1)

Ports:
- m_clock  in  1  system clock; all state on rising edge
- p_reset  in  1  asynchronous, active-low reset
- core_read  in  1  core data read strobe
- core_write  in  1  core data write strobe
- core_addr  in  32  core byte address
- core_wdata  in  32  core write data
- core_rdata  out  32  read data to core
- mon_en  in  1  scanner enable (synchronized MODE)
- mon_sel  in  3  shadow word selected for display
- mon_data  out  32  shadow[mon_sel]
- mon_valid  out  1  at least one full scan completed
- ram_addr  out  32  RAM byte address
- ram_wdata  out  32  RAM write data
- ram_rden  out  1  RAM read enable
- ram_wren  out  1  RAM write enable
- ram_rdata  in  32  RAM read data, valid one cycle after ram_rden

## Operation
- **Core path, combinational pass-through.**
  - When core_read or core_write is high: ram_addr=core_addr, ram_wdata=core_wdata, ram_rden=core_read, ram_wren=core_write.
  - core_rdata=ram_rdata at all times.
- **Scanner FSM.**
  - IDLE → ISSUE when mon_en=1 and the refresh timer has expired. After reset the timer starts expired, so the first scan begins immediately.
  - ISSUE:
    - In a cycle with no core request, drive ram_rden=1 and ram_addr=MON_BASE+4·idx, set pend=1 and pend_idx=idx, then increment idx.
    - A cycle taken by the core is a retry; idx does not advance.
    - After idx=MON_WORDS−1 is issued, go to GAP and load the timer with REFRESH.
  - GAP: the timer decrements each cycle; at 0 go to IDLE.
- **Capture.** When pend=1, shadow[pend_idx] ← ram_rdata at the end of that cycle.
- **mon_valid.** Set on the capture of the last index of a scan. Cleared only by reset.
- **Write snoop.**
  - A core write to MON_BASE ≤ addr < MON_BASE+4·MON_WORDS with addr[1:0]=0 updates shadow[(addr−MON_BASE)>>2] ← core_wdata.
  - If a snoop and a capture hit the same index in the same cycle, the snoop wins.
- **Disable.**
  - mon_en=0 forces IDLE at the next edge. An outstanding pend capture still completes.
  - idx resets to 0 and the shadows hold their values.
- **Idle defaults.** When neither side uses the RAM: ram_addr=0, ram_wdata=0, rden=0, wren=0.
- **mon_sel.** A value ≥ MON_WORDS makes mon_data=0.

## Timing
- Reset values:
  - shadows 0, mon_valid 0, pend 0, idx 0, FSM IDLE, timer 0.
  - Outputs follow the idle defaults: ram_rden=0, ram_wren=0, core_rdata=ram_rdata.
- Core latency matches direct RAM: request at cycle t, data on core_rdata at t+1.
- Scanner read issued at cycle t updates the shadow at the edge ending t+1; mon_data reflects it from t+2.
- Uncontended scan with MON_WORDS=4: issues at t..t+3, mon_valid rises at the edge ending t+4, GAP entered at t+4.
- Back-to-back issue is allowed. A pending capture never blocks a new issue.
- An asynchronous reset mid-scan aborts the scan; a pending capture is discarded.

## Structure
- Shared package `riscv_pkg`:
  - scanner state encoding (IDLE/ISSUE/GAP)
  - default MON_BASE
  - the RAM read-latency constant (1)
- One sub-module, `refresh_timer`: loadable down-counter with an `expired` flag, width $clog2(REFRESH+1).
- FSM, idx/pend registers, shadow array and the address-window compare stay in `dmem_arbiter`.

## Test plan
- **Reset, then idle scan.** Preload RAM 0x200..0x20C = 11,22,33,44; mon_en=1, core idle.
  - rden at cycles 0–3 with addr 0x200/204/208/20C.
  - mon_valid=1 after cycle 4; mon_sel=2 → mon_data=33.
- **Contention.** core_read every other cycle during a scan.
  - Core addresses reach the RAM unchanged.
  - Scanner issues only in the free cycles; all 4 shadows are correct; core_rdata matches the RAM.
- **Snoop.** Core writes 0x200←0xDEAD in the same cycle the capture of idx 0 occurs → shadow[0]=0xDEAD. A write to 0x210 leaves the shadows unchanged.
- **Disable mid-scan.** mon_en=0 after 2 issues.
  - No further rden; shadows 0 and 1 are updated.
  - Re-enable → the scan restarts at 0x200.
- **Refresh.** REFRESH=10: the next scan's first rden occurs exactly 11 cycles after the last issue of the previous scan.
- **Async reset mid-capture.** p_reset low in the capture cycle → shadows 0, mon_valid 0, ram_rden 0 immediately.
